// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data-memory responder
package dmem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word array with per-byte write enables and registered read
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LANES-1:0]  be,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Contents and read register are deliberately unreset; the responder masks rdata.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - handshaked load/store responder with configurable wait states
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [LANES-1:0]  req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state, state_nx;
  logic [3:0]        cnt;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [LANES-1:0]  wstrb_q;
  logic              err_q, load_q;
  logic              accept, wait_done, addr_err;
  logic              arr_we, arr_re;
  logic [WORD_W-1:0] arr_rdata;

  assign accept    = req_valid && (state == ST_IDLE);
  assign wait_done = (cnt == 4'(WAIT_CYCLES - 1));
  assign addr_err  = ((addr_q[1:0] & ALIGN_MASK) != 2'b00) || (addr_q[31:AW+2] != '0);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (req_valid) state_nx = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (wait_done) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   if (resp_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (state == ST_WAIT) cnt <= wait_done ? 4'd0 : cnt + 4'd1;
      if (state == ST_ACCESS) begin
        err_q  <= addr_err;
        load_q <= !we_q && !addr_err;
      end
    end
  end

  // Enables derive from the live state, so an async reset during ACCESS drops the write.
  assign arr_we = (state == ST_ACCESS) && we_q && !addr_err;
  assign arr_re = (state == ST_ACCESS) && !we_q && !addr_err;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (wstrb_q),
    .re    (arr_re),
    .addr  (addr_q[AW+1:2]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = (state == ST_RESP) && err_q;
  assign resp_rdata = ((state == ST_RESP) && load_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at WAIT_CYCLES 1, 0 and 3
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_wstrb  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  logic [31:0] model [3][DEPTH];
  logic [32:0] sb [$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  function automatic int wait_of(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 0 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_wstrb  (req_wstrb[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // Response channel is sampled on negedges; latency counts negedges after the accept edge.
  task automatic do_req(input int idx, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] strb, input int bp);
    logic        ee;
    logic [31:0] er;
    logic [32:0] exp;
    int          lat;
    bit          seen;
    ee = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
    er = (!we && !ee) ? model[idx][addr[7:2]] : 32'h0;
    if (we && !ee)
      for (int i = 0; i < 4; i++)
        if (strb[i]) model[idx][addr[7:2]][8*i +: 8] = wdata[8*i +: 8];
    sb.push_back({ee, er});

    @(negedge clk);
    check("req_ready_idle", 32'(req_ready[idx]), 32'h1);
    req_valid[idx] = 1'b1;
    req_we[idx]    = we;
    req_addr[idx]  = addr;
    req_wdata[idx] = wdata;
    req_wstrb[idx] = strb;
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
    req_we[idx]    = ~we;
    req_addr[idx]  = ~addr;
    req_wdata[idx] = ~wdata;
    req_wstrb[idx] = ~strb;

    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (resp_valid[idx]) seen = 1'b1;
      else if (req_ready[idx]) check("req_ready_busy", 32'(req_ready[idx]), 32'h0);
    end
    check("latency", 32'(lat), 32'(wait_of(idx) + 2));
    exp = sb.pop_front();
    if (!seen) return;

    for (int b = 0; b <= bp; b++) begin
      if (b > 0) @(negedge clk);
      check("resp_valid", 32'(resp_valid[idx]), 32'h1);
      check("resp_rdata", resp_rdata[idx], exp[31:0]);
      check("resp_err", 32'(resp_err[idx]), 32'(exp[32]));
      check("req_ready_resp", 32'(req_ready[idx]), 32'h0);
    end
    resp_ready[idx] = 1'b1;
    @(posedge clk);
    #1;
    resp_ready[idx] = 1'b0;
    @(negedge clk);
    check("resp_valid_after", 32'(resp_valid[idx]), 32'h0);
    check("req_ready_after", 32'(req_ready[idx]), 32'h1);
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_wstrb[i] = '0; resp_ready[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'h1);
      check("rst_resp_valid", 32'(resp_valid[i]), 32'h0);
      check("rst_resp_rdata", resp_rdata[i], 32'h0);
      check("rst_resp_err", 32'(resp_err[i]), 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;

    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    do_req(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
    check("strb_model", model[0][4], 32'hDE22BE44);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 0);
    do_req(0, 1'b1, 32'h00, 32'h5A5A0000, 4'hF, 0);
    do_req(0, 1'b0, 32'h13, 32'h0, 4'h0, 0);
    do_req(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0);
    do_req(0, 1'b0, 32'h00, 32'h0, 4'h0, 0);
    do_req(0, 1'b1, 32'h10, 32'h99999999, 4'h0, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);

    do_req(1, 1'b1, 32'h40, 32'h12345678, 4'hF, 0);
    do_req(1, 1'b0, 32'h40, 32'h0, 4'h0, 2);
    do_req(2, 1'b1, 32'h44, 32'hA5C3E1F0, 4'b1001, 0);
    do_req(2, 1'b1, 32'h44, 32'h0F1E2D3C, 4'b0110, 0);
    do_req(2, 1'b0, 32'h44, 32'h0, 4'h0, 1);
    do_req(2, 1'b0, 32'hFC, 32'h0, 4'h0, 0);

    do_req(2, 1'b1, 32'h20, 32'h00000000, 4'hF, 0);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h20;
    req_wdata[2] = 32'hCAFEF00D; req_wstrb[2] = 4'hF;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    check("mid_wait_busy", 32'(req_ready[2]), 32'h0);
    reset = 1'b0;
    #1;
    check("async_req_ready", 32'(req_ready[2]), 32'h1);
    check("async_resp_valid", 32'(resp_valid[2]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_req(2, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
